// File: rtl/param_shift_reg.sv
// param_shift_reg: multi-mode shift register.
// It shifts, rotates or arithmetic-shifts right by a requested number of one-bit
// steps, using one step per clock, or it loads parallel data. A three-state
// controller (IDLE / SHIFT / DONE) sequences the steps and reports progress on
// busy/done.
// Optional feature: define SHIFT_REG_BITOUT_EN to add the shift_out port. This
// port holds the bit that left the register on the most recent step.
module param_shift_reg #(
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AW-1:0]    amount,
  input  logic             serial_rs,
  input  logic             serial_ls,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] s_out,
  output logic             busy,
  output logic             done
`ifdef SHIFT_REG_BITOUT_EN
  ,
  output logic             shift_out
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    MODE_NOP  = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  state_e           state;
  mode_e            mode_q;
  mode_e            req_mode;
  logic [AW-1:0]    cnt;
  logic [AW-1:0]    amount_sat;
  logic             req_step;
  logic [WIDTH-1:0] step_val;

  function automatic logic is_step_mode(input mode_e m);
    return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
           (m == MODE_ROL) || (m == MODE_ASR);
  endfunction

  // Decode the incoming request: saturate the step count, and decide whether
  // the request needs the SHIFT state.
  always_comb begin
    req_mode   = mode_e'(mode);
    amount_sat = (amount > AW'(WIDTH)) ? AW'(WIDTH) : amount;
    req_step   = is_step_mode(req_mode) && (amount != '0);
  end

  // One-bit step of the captured mode; serial fill bits are taken live.
  always_comb begin
    step_val = s_out;
    case (mode_q)
      MODE_SHR: step_val = {serial_rs, s_out[WIDTH-1:1]};
      MODE_SHL: step_val = {s_out[WIDTH-2:0], serial_ls};
      MODE_ROR: step_val = {s_out[0], s_out[WIDTH-1:1]};
      MODE_ROL: step_val = {s_out[WIDTH-2:0], s_out[WIDTH-1]};
      MODE_ASR: step_val = {s_out[WIDTH-1], s_out[WIDTH-1:1]};
      default:  step_val = s_out;
    endcase
  end

  // Controller, datapath register and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      mode_q <= MODE_NOP;
      cnt    <= '0;
      s_out  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_SHIFT: begin
          s_out <= step_val;
          cnt   <= cnt - AW'(1);
          if (cnt == AW'(1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE accept requests identically, which allows
          // back-to-back operation out of DONE.
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            if (req_step) begin
              mode_q <= req_mode;
              cnt    <= amount_sat;
              state  <= ST_SHIFT;
              busy   <= 1'b1;
            end else begin
              if (req_mode == MODE_LOAD) begin
                s_out <= parallel_in;
              end
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef SHIFT_REG_BITOUT_EN
  logic step_bit;

  // Bit that leaves the register on a step: LSB for right-going modes, MSB otherwise.
  always_comb begin
    step_bit = 1'b0;
    case (mode_q)
      MODE_SHR, MODE_ROR, MODE_ASR: step_bit = s_out[0];
      MODE_SHL, MODE_ROL:           step_bit = s_out[WIDTH-1];
      default:                      step_bit = 1'b0;
    endcase
  end

  // Capture the ejected bit on step edges only; hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_out <= 1'b0;
    end else if (state == ST_SHIFT) begin
      shift_out <= step_bit;
    end
  end
`endif

endmodule

// File: tb/tb_param_shift_reg.sv
// Self-checking bench for param_shift_reg (WIDTH=8).
// The bench first replays a directed vector table, and then runs randomised
// traffic against a transaction-level reference model.
module tb_param_shift_reg;

  localparam int W  = 8;
  localparam int AW = $clog2(W) + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [2:0]    mode;
  logic [AW-1:0] amount;
  logic          serial_rs;
  logic          serial_ls;
  logic [W-1:0]  parallel_in;
  logic [W-1:0]  s_out;
  logic          busy;
  logic          done;
`ifdef SHIFT_REG_BITOUT_EN
  logic          shift_out;
`endif

  int checks   = 0;
  int failures = 0;

  param_shift_reg #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .amount      (amount),
    .serial_rs   (serial_rs),
    .serial_ls   (serial_ls),
    .parallel_in (parallel_in),
    .s_out       (s_out),
    .busy        (busy),
    .done        (done)
`ifdef SHIFT_REG_BITOUT_EN
    ,
    .shift_out   (shift_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         start;
    logic [2:0]   mode;
    logic [3:0]   amt;
    logic         srs;
    logic         sls;
    logic [7:0]   pin;
    logic [7:0]   es;
    logic         eb;
    logic         ed;
    logic         eso;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic r, input logic s, input logic [2:0] m,
                            input logic [3:0] a, input logic rs, input logic ls,
                            input logic [7:0] p, input logic [7:0] es,
                            input logic eb, input logic ed, input logic eso);
    vec_t t;
    t.rst = r; t.start = s; t.mode = m; t.amt = a; t.srs = rs; t.sls = ls;
    t.pin = p; t.es = es; t.eb = eb; t.ed = ed; t.eso = eso;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: remaining-step count plus current register value.
  logic [W-1:0] m_s;
  int           m_rem;
  int           m_mode;
  logic         m_busy, m_done, m_so;

  task automatic model_update();
    int n;
    if (rst) begin
      m_s = '0; m_rem = 0; m_busy = 0; m_done = 0; m_so = 0;
    end else if (m_rem > 0) begin
      case (m_mode)
        1: begin m_so = m_s[0];   m_s = (m_s >> 1) | (W'(serial_rs) << (W-1)); end
        2: begin m_so = m_s[W-1]; m_s = (m_s << 1) | W'(serial_ls); end
        4: begin m_so = m_s[0];   m_s = (m_s >> 1) | (m_s << (W-1)); end
        5: begin m_so = m_s[W-1]; m_s = (m_s << 1) | (m_s >> (W-1)); end
        6: begin m_so = m_s[0];   m_s = (m_s >> 1) | (m_s & (W'(1) << (W-1))); end
        default: ;
      endcase
      m_rem--;
      m_busy = (m_rem > 0);
      m_done = (m_rem == 0);
    end else begin
      m_busy = 0;
      m_done = 0;
      if (start) begin
        n = (int'(amount) > W) ? W : int'(amount);
        if ((mode == 1 || mode == 2 || mode == 4 || mode == 5 || mode == 6) && n > 0) begin
          m_rem  = n;
          m_mode = int'(mode);
          m_busy = 1;
        end else begin
          if (mode == 3) m_s = parallel_in;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic apply(input vec_t t);
    rst = t.rst; start = t.start; mode = t.mode; amount = t.amt;
    serial_rs = t.srs; serial_ls = t.sls; parallel_in = t.pin;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = '0; amount = '0;
    serial_rs = 1'b0; serial_ls = 1'b0; parallel_in = '0;

    //  rst st md amt rs ls pin    s_out  busy done so
    v(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);   // reset
    v(0, 1, 3, 0, 0, 0, 8'hA5, 8'hA5, 0, 1, 0);   // load
    v(0, 0, 0, 0, 0, 0, 8'h00, 8'hA5, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 8'h00, 8'hA5, 0, 0, 0);
    v(0, 1, 1, 3, 1, 0, 8'h00, 8'hA5, 1, 0, 0);   // shr 3, fill 1
    v(0, 0, 0, 0, 1, 0, 8'h00, 8'hD2, 1, 0, 1);
    v(0, 0, 0, 0, 1, 0, 8'h00, 8'hE9, 1, 0, 0);
    v(0, 0, 0, 0, 1, 0, 8'h00, 8'hF4, 0, 1, 1);
    v(0, 0, 0, 0, 0, 0, 8'h00, 8'hF4, 0, 0, 1);
    v(0, 1, 3, 0, 0, 0, 8'h81, 8'h81, 0, 1, 1);   // load 0x81
    v(0, 1, 5, 8, 0, 0, 8'h00, 8'h81, 1, 0, 1);   // rol 8 from DONE
    v(0, 0, 0, 0, 0, 0, 8'h00, 8'h03, 1, 0, 1);
    v(0, 0, 0, 0, 0, 0, 8'h00, 8'h06, 1, 0, 0);
    v(0, 0, 0, 0, 0, 0, 8'h00, 8'h0C, 1, 0, 0);
    v(0, 0, 0, 0, 0, 0, 8'h00, 8'h18, 1, 0, 0);
    v(0, 0, 0, 0, 0, 0, 8'h00, 8'h30, 1, 0, 0);
    v(0, 0, 0, 0, 0, 0, 8'h00, 8'h60, 1, 0, 0);
    v(0, 0, 0, 0, 0, 0, 8'h00, 8'hC0, 1, 0, 0);
    v(0, 0, 0, 0, 0, 0, 8'h00, 8'h81, 0, 1, 1);
    v(0, 1, 3, 0, 0, 0, 8'h80, 8'h80, 0, 1, 1);   // load 0x80
    v(0, 1, 6, 2, 0, 0, 8'h00, 8'h80, 1, 0, 1);   // asr 2
    v(0, 0, 0, 0, 0, 0, 8'h00, 8'hC0, 1, 0, 0);
    v(0, 0, 0, 0, 0, 0, 8'h00, 8'hE0, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 8'h00, 8'hE0, 0, 0, 0);
    v(0, 1, 1, 4, 0, 0, 8'h00, 8'hE0, 1, 0, 0);   // shr 4, fill 0
    v(0, 1, 3, 0, 0, 0, 8'h55, 8'h70, 1, 0, 0);   // load while busy: ignored
    v(0, 1, 3, 0, 0, 0, 8'h55, 8'h38, 1, 0, 0);
    v(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);   // abort by reset
    v(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);   // no done afterwards
    v(0, 1, 3, 0, 0, 0, 8'h01, 8'h01, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0);
    v(0, 1, 2, 0, 0, 0, 8'h00, 8'h01, 0, 1, 0);   // amount 0
    v(0, 1, 2, 1, 0, 1, 8'h00, 8'h01, 1, 0, 0);   // start held in DONE
    v(0, 1, 2, 1, 0, 1, 8'h00, 8'h03, 0, 1, 0);
    v(0, 1, 2, 1, 0, 1, 8'h00, 8'h03, 1, 0, 0);   // back-to-back
    v(0, 0, 0, 0, 0, 1, 8'h00, 8'h07, 0, 1, 0);
    v(0, 0, 0, 0, 0, 0, 8'h00, 8'h07, 0, 0, 0);
    v(0, 1, 3, 0, 0, 0, 8'hFF, 8'hFF, 0, 1, 0);
    v(0, 1, 2, 15, 0, 0, 8'h00, 8'hFF, 1, 0, 0);  // amount saturates to 8
    for (int k = 0; k < 8; k++)
      v(0, 0, 0, 0, 0, 0, 8'h00, 8'hFF << (k + 1), k < 7, k == 7, 1);
    v(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1);
    v(0, 1, 7, 3, 0, 0, 8'h00, 8'h00, 0, 1, 1);   // reserved mode
    v(0, 1, 0, 5, 0, 0, 8'hAA, 8'h00, 0, 1, 1);   // nop mode
    v(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      tick();
      chk($sformatf("vec%0d_s_out", i), 64'(s_out), 64'(vecs[i].es));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].eb));
      chk($sformatf("vec%0d_done", i), 64'(done), 64'(vecs[i].ed));
`ifdef SHIFT_REG_BITOUT_EN
      chk($sformatf("vec%0d_shift_out", i), 64'(shift_out), 64'(vecs[i].eso));
`endif
    end

    // Randomised traffic against the model.
    rst = 1'b1; start = 1'b0;
    tick();
    model_update();
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 149) == 0);
      start       = ($urandom_range(0, 2) == 0);
      mode        = 3'($urandom_range(0, 7));
      amount      = AW'($urandom_range(0, 15));
      serial_rs   = 1'($urandom);
      serial_ls   = 1'($urandom);
      parallel_in = W'($urandom);
      tick();
      model_update();
      chk($sformatf("rnd%0d_s_out", c), 64'(s_out), 64'(m_s));
      chk($sformatf("rnd%0d_busy", c), 64'(busy), 64'(m_busy));
      chk($sformatf("rnd%0d_done", c), 64'(done), 64'(m_done));
`ifdef SHIFT_REG_BITOUT_EN
      chk($sformatf("rnd%0d_shift_out", c), 64'(shift_out), 64'(m_so));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_shift_reg.md
PARAM_SHIFT_REG -- requirements
Module: param_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning register width in bits (legal 2..64).
REQ-002 SHALL derive localparam AW = $clog2(WIDTH)+1, the amount/counter width (holds 0..WIDTH).
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk, rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  request; sampled only in IDLE or DONE.
REQ-007 mode  input  3  operation select, captured with start.
REQ-008 amount  input  AW  number of one-bit steps, captured with start.
REQ-009 serial_rs  input  1  fill bit for right shift (enters MSB).
REQ-010 serial_ls  input  1  fill bit for left shift (enters LSB).
REQ-011 parallel_in  input  WIDTH  load data.
REQ-012 s_out  output  WIDTH  register contents.
REQ-013 busy  output  1  high while in SHIFT.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 mode encoding SHALL be: 000 nop, 001 shift right, 010 shift left, 011 parallel load, 100 rotate right, 101 rotate left, 110 arithmetic shift right (MSB replicated), 111 reserved (treated as nop).
REQ-016 FSM SHALL have states IDLE, SHIFT, DONE; busy = (state==SHIFT), done = (state==DONE).
REQ-017 start in IDLE/DONE with step mode (001,010,100,101,110) and 0 < amount <= WIDTH SHALL capture mode/amount, load counter with amount, enter SHIFT; s_out unchanged on that edge.
REQ-018 Each edge in SHIFT SHALL perform exactly one one-bit step of the captured mode and decrement the counter; the step with counter==1 SHALL transition to DONE.
REQ-019 Serial fill bits SHALL be sampled live at each step edge, not captured at start.
REQ-020 start with mode 011 SHALL load s_out <= parallel_in on that edge and enter DONE.
REQ-021 start with nop/reserved mode, or amount==0, SHALL leave s_out unchanged and enter DONE.
REQ-022 amount > WIDTH SHALL be saturated to WIDTH.
REQ-023 Latency: step operation with amount n SHALL assert done in the cycle after edge n+1 counting the start edge as edge 1; load/nop SHALL assert done the cycle after the start edge.
REQ-024 DONE SHALL last exactly one cycle; with no start it SHALL return to IDLE; start in DONE SHALL be accepted as in IDLE (back-to-back).
REQ-025 start, mode, amount, parallel_in SHALL be ignored while busy.
REQ-026 Rotate by WIDTH SHALL return s_out to its starting value.

Reset
REQ-027 rst high at a clk edge SHALL force s_out=0, counter=0, state=IDLE, busy=0, done=0, overriding any in-progress operation and any start.
REQ-028 A shift aborted by rst SHALL NOT produce a done pulse.

Configuration
REQ-029 Macro SHIFT_REG_BITOUT_EN, when defined, SHALL add output shift_out (1 bit): the bit shifted/rotated out on the most recent step edge, reset to 0, held otherwise, unchanged by load/nop.
REQ-030 Without SHIFT_REG_BITOUT_EN the shift_out port and its register SHALL be absent; all other behaviour identical.

Verification (WIDTH=8)
REQ-031 rst; start mode=011 parallel_in=0xA5 -> s_out=0xA5 next cycle, done=1 one cycle, busy never high.
REQ-032 s_out=0xA5; start mode=001 amount=3 serial_rs=1 -> busy 3 cycles, s_out 0xD2,0xE9,0xF4, then done=1 one cycle; shift_out (if enabled) 1,0,1.
REQ-033 s_out=0x81; start mode=101 amount=8 -> s_out=0x81 at done; mode=110 amount=2 on 0x80 -> 0xE0.
REQ-034 Mid-SHIFT start with mode=011 -> ignored, s_out unchanged by parallel_in; rst asserted mid-SHIFT -> s_out=0, busy=0, no done.
REQ-035 start amount=0 mode=010 -> done next cycle, s_out unchanged; start held high in DONE with mode=010 amount=1 serial_ls=1 on 0x01 -> s_out=0x03, back-to-back done.
REQ-036 amount=15 mode=010 serial_ls=0 on 0xFF -> exactly 8 busy cycles, s_out=0x00.
